// File: rtl/keypad_varredura.sv
// keypad_varredura
// Scans and debounces the 4x4 matrix keypad. Columns are driven low one at
// a time. After a settle interval the synchronized rows are latched for that
// column. Each full scan is reduced to a single key code. A new code is
// accepted once DEBOUNCE consecutive scans agree on it.
//
// Ports:
//   clk          system clock (1000 Hz)
//   rst          synchronous, active-high reset
//   kpd_linhas   row inputs, active-low, asynchronous to clk
//   kpd_colunas  column drives, active-low, exactly one bit low
//   tecla_atual  debounced key code (0-15, 31 = no key)
//   tecla_pulso  one-cycle strobe when tecla_atual takes a new key value
module keypad_varredura #(
    parameter int SETTLE   = 3,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] kpd_linhas,
    output logic [3:0] kpd_colunas,
    output logic [4:0] tecla_atual,
    output logic       tecla_pulso
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE);
    localparam logic [4:0]    NENHUMA    = 5'd31;

    // Key code for matrix position idx = row*4 + col.
    function automatic logic [4:0] codigo_tecla(input logic [3:0] idx);
        case (idx)
            4'd0:    codigo_tecla = 5'd1;
            4'd1:    codigo_tecla = 5'd2;
            4'd2:    codigo_tecla = 5'd3;
            4'd3:    codigo_tecla = 5'd10;
            4'd4:    codigo_tecla = 5'd4;
            4'd5:    codigo_tecla = 5'd5;
            4'd6:    codigo_tecla = 5'd6;
            4'd7:    codigo_tecla = 5'd11;
            4'd8:    codigo_tecla = 5'd7;
            4'd9:    codigo_tecla = 5'd8;
            4'd10:   codigo_tecla = 5'd9;
            4'd11:   codigo_tecla = 5'd12;
            4'd12:   codigo_tecla = 5'd14;
            4'd13:   codigo_tecla = 5'd0;
            4'd14:   codigo_tecla = 5'd15;
            default: codigo_tecla = 5'd13;
        endcase
    endfunction

    // Reduce the 16 pressed flags to a code. Anything other than exactly one
    // key is treated as no key, which also rejects ghosting.
    function automatic logic [4:0] resolve_varredura(input logic [15:0] pressed);
        int         n;
        logic [4:0] code;
        n    = 0;
        code = NENHUMA;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                n    = n + 1;
                code = codigo_tecla(4'(i));
            end
        end
        resolve_varredura = (n == 1) ? code : NENHUMA;
    endfunction

    // Saturating increment for the debounce counter.
    function automatic logic [CW-1:0] sat_incr(input logic [CW-1:0] v);
        sat_incr = (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [1:0]      col;
    logic [SW-1:0]   settle;
    logic [3:0]      amostra_c0;
    logic [3:0]      amostra_c1;
    logic [3:0]      amostra_c2;
    logic [4:0]      candidato;
    logic [CW-1:0]   cnt;

    logic [3:0][3:0] linhas_scan;
    logic [15:0]     pressionadas;
    logic [4:0]      resultado;
    logic            amostrar;
    logic            fim_varredura;
    logic [4:0]      cand_next;
    logic [CW-1:0]   cnt_next;
    logic            aceita;

    assign kpd_colunas = ~(4'b0001 << col);

    assign amostrar      = (settle == SETTLE_MAX);
    assign fim_varredura = amostrar && (col == 2'd3);

    // Column 3 is never stored; it is taken from the live synchronized rows
    // on the same cycle the scan is evaluated.
    assign linhas_scan = {sync_p1, amostra_c2, amostra_c1, amostra_c0};

    always_comb begin
        pressionadas = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                pressionadas[r*4 + c] = ~linhas_scan[c][r];
            end
        end
    end

    assign resultado = resolve_varredura(pressionadas);

    always_comb begin
        cand_next = candidato;
        cnt_next  = cnt;
        if (resultado == candidato) begin
            cnt_next = sat_incr(cnt);
        end else begin
            cand_next = resultado;
            cnt_next  = CW'(1);
        end
    end

    // Acceptance looks at the post-update count, so the output changes on the
    // same edge that completes the DEBOUNCE-th agreeing scan.
    assign aceita = fim_varredura && (cnt_next == CNT_MAX) && (cand_next != tecla_atual);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0     <= 4'b1111;
            sync_p1     <= 4'b1111;
            col         <= 2'd0;
            settle      <= '0;
            amostra_c0  <= 4'b1111;
            amostra_c1  <= 4'b1111;
            amostra_c2  <= 4'b1111;
            candidato   <= NENHUMA;
            cnt         <= '0;
            tecla_atual <= NENHUMA;
            tecla_pulso <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop row synchronizer
            sync_p0     <= kpd_linhas;
            sync_p1     <= sync_p0;
            tecla_pulso <= 1'b0;

            if (amostrar) begin
                settle <= '0;
                col    <= col + 2'd1;
                case (col)
                    2'd0:    amostra_c0 <= sync_p1;
                    2'd1:    amostra_c1 <= sync_p1;
                    2'd2:    amostra_c2 <= sync_p1;
                    default: ;
                endcase
                if (fim_varredura) begin
                    candidato <= cand_next;
                    cnt       <= cnt_next;
                    if (aceita) begin
                        tecla_atual <= cand_next;
                        tecla_pulso <= (cand_next != NENHUMA);
                    end
                end
            end else begin
                settle <= settle + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_varredura.sv
module tb_keypad_varredura;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  kpd_linhas;
    logic [3:0]  kpd_colunas;
    logic [4:0]  tecla_atual;
    logic        tecla_pulso;
    logic [15:0] teclas;   // pressed keys, index row*4 + col

    int checks   = 0;
    int failures = 0;

    keypad_varredura #(.SETTLE(3), .DEBOUNCE(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .kpd_linhas  (kpd_linhas),
        .kpd_colunas (kpd_colunas),
        .tecla_atual (tecla_atual),
        .tecla_pulso (tecla_pulso)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is low.
    always_comb begin
        kpd_linhas = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (teclas[r*4 + c] && !kpd_colunas[c]) kpd_linhas[r] = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 with the given keys held.
    task automatic do_reset(input logic [15:0] keys);
        rst    = 1'b1;
        teclas = keys;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst    = 1'b1;
        teclas = 16'h0100;  // '7' at r2,c0
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (kpd_colunas !== 4'b1110) begin
                failures++;
                $display("FAIL reset_colunas i=%0d got=%b exp=1110", i, kpd_colunas);
            end
            checks++;
            if (tecla_atual !== 5'd31) begin
                failures++;
                $display("FAIL reset_tecla i=%0d got=%0d exp=31", i, tecla_atual);
            end
            checks++;
            if (tecla_pulso !== 1'b0) begin
                failures++;
                $display("FAIL reset_pulso i=%0d got=%b exp=0", i, tecla_pulso);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_col = 4'b1111;
            exp_col[k/4] = 1'b0;
            checks++;
            if (kpd_colunas !== exp_col) begin
                failures++;
                $display("FAIL rotacao_colunas cycle=%0d got=%b exp=%b", k, kpd_colunas, exp_col);
            end
            step();
        end
    endtask

    // '5' held from cycle 0, released at cycle 100. The release is seen by
    // the column-1 sample of the scan ending at cycle 111, so scans ending
    // at 111/127/143 are empty and tecla_atual returns to 31 in cycle 144.
    task automatic test_single_press();
        logic [4:0] exp_t;
        do_reset(16'h0020);
        for (int k = 0; k < 200; k++) begin
            if (k == 100) teclas = 16'h0000;
            exp_t = (k >= 48 && k < 144) ? 5'd5 : 5'd31;
            checks++;
            if (tecla_atual !== exp_t) begin
                failures++;
                $display("FAIL single_tecla cycle=%0d got=%0d exp=%0d", k, tecla_atual, exp_t);
            end
            checks++;
            if (tecla_pulso !== (k == 48)) begin
                failures++;
                $display("FAIL single_pulso cycle=%0d got=%b exp=%b", k, tecla_pulso, k == 48);
            end
            step();
        end
    endtask

    // '#' (r3,c2) pressed while (cycle/5) is even up to cycle 60, then held.
    task automatic test_bounce();
        logic [4:0] exp_t;
        int         pulsos;
        pulsos = 0;
        do_reset(16'h4000);
        for (int k = 0; k < 160; k++) begin
            teclas = (k > 60 || ((k / 5) % 2) == 0) ? 16'h4000 : 16'h0000;
            exp_t  = (k >= 112) ? 5'd15 : 5'd31;
            if (tecla_pulso === 1'b1) pulsos++;
            checks++;
            if (tecla_atual !== exp_t) begin
                failures++;
                $display("FAIL bounce_tecla cycle=%0d got=%0d exp=%0d", k, tecla_atual, exp_t);
            end
            checks++;
            if (tecla_pulso !== (k == 112)) begin
                failures++;
                $display("FAIL bounce_pulso cycle=%0d got=%b exp=%b", k, tecla_pulso, k == 112);
            end
            step();
        end
        checks++;
        if (pulsos != 1) begin
            failures++;
            $display("FAIL bounce_num_pulsos got=%0d exp=1", pulsos);
        end
    endtask

    task automatic test_multi_press();
        do_reset(16'h8001);  // '1' (r0,c0) and 'D' (r3,c3)
        for (int k = 0; k < 200; k++) begin
            checks++;
            if (tecla_atual !== 5'd31) begin
                failures++;
                $display("FAIL multi_tecla cycle=%0d got=%0d exp=31", k, tecla_atual);
            end
            checks++;
            if (tecla_pulso !== 1'b0) begin
                failures++;
                $display("FAIL multi_pulso cycle=%0d got=%b exp=0", k, tecla_pulso);
            end
            step();
        end
        teclas = 16'h0000;
    endtask

    // 'A' (r0,c3) for cycles 0-99, then 'B' (r1,c3). Column 3 of the scan
    // ending at cycle 111 already sees 'B'; acceptance at 143 -> cycle 144.
    task automatic test_slide();
        logic [4:0] exp_t;
        logic       exp_p;
        do_reset(16'h0008);
        for (int k = 0; k < 200; k++) begin
            if (k == 100) teclas = 16'h0080;
            exp_t = (k < 48) ? 5'd31 : ((k < 144) ? 5'd10 : 5'd11);
            exp_p = (k == 48) || (k == 144);
            checks++;
            if (tecla_atual !== exp_t) begin
                failures++;
                $display("FAIL slide_tecla cycle=%0d got=%0d exp=%0d", k, tecla_atual, exp_t);
            end
            checks++;
            if (tecla_pulso !== exp_p) begin
                failures++;
                $display("FAIL slide_pulso cycle=%0d got=%b exp=%b", k, tecla_pulso, exp_p);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        logic [4:0] exp_t;
        do_reset(16'h0400);  // '9' at r2,c2
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (tecla_atual !== 5'd31) begin
                failures++;
                $display("FAIL midrst_pre_tecla cycle=%0d got=%0d exp=31", k, tecla_atual);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (kpd_colunas !== 4'b1110) begin
            failures++;
            $display("FAIL midrst_colunas got=%b exp=1110", kpd_colunas);
        end
        for (int k = 0; k < 64; k++) begin
            exp_t = (k >= 48) ? 5'd9 : 5'd31;
            checks++;
            if (tecla_atual !== exp_t) begin
                failures++;
                $display("FAIL midrst_tecla cycle=%0d got=%0d exp=%0d", k, tecla_atual, exp_t);
            end
            checks++;
            if (tecla_pulso !== (k == 48)) begin
                failures++;
                $display("FAIL midrst_pulso cycle=%0d got=%b exp=%b", k, tecla_pulso, k == 48);
            end
            step();
        end
    endtask

    initial begin
        rst    = 1'b1;
        teclas = 16'h0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_press();
        test_slide();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
